serial_add_controller: RTL and testbench

Sequencer that runs the team's registered full-adder cell (three-input adder plus sum/carry D flip-flops) as a bit-serial WIDTH-bit adder. Operands are accepted with a start/ready handshake, fed LSB-first one bit per clock with the registered carry fed back, and the assembled sum and carry-out are published with a one-cycle done pulse. It lets one full-adder slice serve wide additions in the datapath at one bit per cycle.

---
 rtl/serial_add_controller_if.sv | 25 ++
 rtl/serial_add_controller.sv | 107 ++++++++++
 tb/tb_serial_add_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_controller_if.sv
// Handshake and result bundle for serial_add_controller.
// The requester drives start/operands; the controller returns status and result.
interface serial_add_controller_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  ready, busy, sum, cout, done
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, sum, cout, done
    );
endinterface

// File: rtl/serial_add_controller.sv
// Bit-serial WIDTH-bit adder built around one registered full-adder slice.
// Operands are consumed LSB-first, one bit per clock, with the carry fed back.
module serial_add_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    serial_add_controller_if.slave    bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             load;
    logic             step;
    logic             last;
    logic             fa_s;
    logic             fa_c;

    // Full-adder slice on the current LSBs; its sum bit enters the partial sum at the MSB.
    always_comb begin
        fa_s    = sa[0] ^ sb[0] ^ carry;
        fa_c    = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        psum_nx = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            psum   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (load) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (step) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= fa_c;
            psum  <= psum_nx;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the final bit, so partial sums are never visible.
            if (last) begin
                sum_r  <= psum_nx;
                cout_r <= fa_c;
            end
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
endmodule

// File: tb/tb_serial_add_controller.sv
// Randomized self-checking bench for serial_add_controller (WIDTH=8 and WIDTH=1 builds).
// A timeline model predicts every output cycle by cycle from accepted requests.
module tb_serial_add_controller;
    localparam int W = 8;

    bit   clock = 1'b0;
    logic reset;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    serial_add_controller_if #(.WIDTH(W)) bus8 ();
    serial_add_controller_if #(.WIDTH(1)) bus1 ();

    serial_add_controller #(.WIDTH(W)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    serial_add_controller #(.WIDTH(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted request at edge n yields done after edge n+W
    // and frees the unit at edge n+W+1.
    int           edge_n   = 0;
    bit           m_active = 1'b0;
    int           m_acc    = 0;
    logic [W:0]   m_res    = '0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;

    always @(posedge clock) begin
        edge_n++;
        if (reset) begin
            m_active = 1'b0;
            m_sum    = '0;
            m_cout   = 1'b0;
        end else if (m_active) begin
            if (edge_n == m_acc + W) begin
                {m_cout, m_sum} = m_res;
            end else if (edge_n == m_acc + W + 1) begin
                m_active = 1'b0;
            end
        end else if (bus8.start) begin
            m_active = 1'b1;
            m_acc    = edge_n;
            m_res    = {1'b0, bus8.a} + {1'b0, bus8.b} + {{W{1'b0}}, bus8.cin};
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("ready", bus8.ready, !m_active);
            check("busy",  bus8.busy,  m_active);
            check("done",  bus8.done,  m_active && (edge_n == m_acc + W));
            check("sum",   bus8.sum,   m_sum);
            check("cout",  bus8.cout,  m_cout);
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input string nm);
        int acc;
        bit found;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        @(negedge clock);
        acc        = edge_n;
        bus8.start = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            bus8.a   = 8'($urandom);
            bus8.b   = 8'($urandom);
            bus8.cin = 1'($urandom);
            @(negedge clock);
            if (bus8.done) found = 1'b1;
        end
        if (!found) begin
            check({nm, "_timeout"}, 0, 1);
        end else begin
            check({nm, "_latency"}, edge_n - acc, W);
            check({nm, "_sum"}, bus8.sum, es);
            check({nm, "_cout"}, bus8.cout, ec);
            @(negedge clock);
            check({nm, "_ready_back"}, bus8.ready, 1'b1);
        end
    endtask

    initial begin
        int          acc;
        int          dones;
        int          done_edges[$];
        logic [7:0]  ra, rb;
        logic        rc;
        logic [8:0]  rsum;
        logic [1:0]  r1;

        reset     = 1'b1;
        bus8.start = 1'b1;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
        bus1.start = 1'b1;
        bus1.a     = 1'($urandom);
        bus1.b     = 1'($urandom);
        bus1.cin   = 1'($urandom);
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst_ready", bus8.ready, 1'b1);
        check("rst_busy",  bus8.busy,  1'b0);
        check("rst_done",  bus8.done,  1'b0);
        check("rst_sum",   bus8.sum,   8'h00);
        check("rst_cout",  bus8.cout,  1'b0);
        check("rst1_ready", bus1.ready, 1'b1);
        check("rst1_sum",   bus1.sum,   1'b0);
        reset      = 1'b0;
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        @(negedge clock);
        check("post_rst_ready", bus8.ready, 1'b1);

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "chain1");
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "chain2");
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "chain3");

        // Busy rejection with operands scrambled every cycle.
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        bus8.cin   = 1'b0;
        @(negedge clock);
        acc        = edge_n;
        bus8.start = 1'b0;
        dones      = 0;
        for (int i = 0; i < 25; i++) begin
            bus8.a     = 8'($urandom);
            bus8.b     = 8'($urandom);
            bus8.cin   = 1'($urandom);
            bus8.start = 1'b0;
            if (edge_n == acc + 2) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'hFF;
            end
            @(negedge clock);
            if (bus8.done) dones++;
        end
        bus8.start = 1'b0;
        check("busy_rej_dones", dones, 1);
        check("busy_rej_sum",   bus8.sum,  8'h30);
        check("busy_rej_cout",  bus8.cout, 1'b0);

        // Reset in the middle of an operation.
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.cin   = 1'b0;
        @(negedge clock);
        bus8.start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_sum",   bus8.sum,   8'h00);
        check("abort_cout",  bus8.cout,  1'b0);
        check("abort_ready", bus8.ready, 1'b1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus8.done) dones++;
        end
        check("abort_no_done", dones, 0);
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_abort");

        // start held high: one operation every W+2 edges.
        bus8.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus8.a   = 8'($urandom);
            bus8.b   = 8'($urandom);
            bus8.cin = 1'($urandom);
            @(negedge clock);
            if (bus8.done) done_edges.push_back(edge_n);
        end
        bus8.start = 1'b0;
        check("b2b_count", done_edges.size(), 3);
        for (int i = 1; i < done_edges.size(); i++) begin
            check("b2b_spacing", done_edges[i] - done_edges[i-1], W + 2);
        end
        repeat (12) @(negedge clock);

        for (int i = 0; i < 25; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_op(ra, rb, rc, rsum[7:0], rsum[8], "rand");
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // WIDTH=1 build: every input combination.
        for (int v = 0; v < 8; v++) begin
            bus1.start = 1'b1;
            bus1.a     = 1'(v);
            bus1.b     = 1'(v >> 1);
            bus1.cin   = 1'(v >> 2);
            r1 = 2'(v & 1) + 2'((v >> 1) & 1) + 2'((v >> 2) & 1);
            @(negedge clock);
            acc        = edge_n;
            bus1.start = 1'b0;
            bus1.a     = ~bus1.a;
            bus1.b     = ~bus1.b;
            @(negedge clock);
            check("w1_done",    bus1.done, 1'b1);
            check("w1_latency", edge_n - acc, 1);
            check("w1_sum",     bus1.sum,  r1[0]);
            check("w1_cout",    bus1.cout, r1[1]);
            @(negedge clock);
            check("w1_done_low", bus1.done,  1'b0);
            check("w1_ready",    bus1.ready, 1'b1);
        end
        check("w1_last_sum",  bus1.sum,  1'b1);
        check("w1_last_cout", bus1.cout, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
